// File: rtl/pipe_add.sv
// ---------------------------------------------------------------------------
// pipe_add -- pipelined ripple-carry adder with a valid/ready handshake.
//
// The WIDTH-bit addition is split into STAGES chunks of CW = WIDTH/STAGES
// bits. Stage k adds chunk k of the operands plus the carry registered by
// stage k-1 (stage 0 uses cin). Operand chunks that are still to be added
// ride along in skew registers. Sum chunks that are already finished ride
// along in de-skew registers. As a result the full sum leaves the last
// stage on a single cycle.
//
// The whole pipeline advances together. When the result at the output is
// valid but not taken, the pipeline freezes: in_ready drops, and every
// register holds its value.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   in_valid   in   operand set a/b/cin presented
//   in_ready   out  operand set accepted this cycle (combinational)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry in
//   out_valid  out  sum/cout/ovf valid
//   out_ready  in   downstream accepts the result
//   sum        out  a + b + cin mod 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  signed overflow (carry into MSB xor carry out of MSB)
// ---------------------------------------------------------------------------
module pipe_add #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    logic                          adv;
    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0]             carry_q, carry_d;
    // Skew (operands) and de-skew (partial sums) registers. Each entry is kept
    // full width to keep the code simple. Bits that a stage never uses are
    // constant or unused, so synthesis trims them away.
    logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0]  b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0]  sum_q, sum_d;
    logic                          ovf_q, ovf_d;
    logic                          unused_skew;

    // One global advance: the pipeline moves whenever the output slot is
    // empty or is being drained this cycle.
    assign adv      = !valid_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] src_a;
            logic [WIDTH-1:0] src_b;
            logic [WIDTH-1:0] src_sum;
            logic             src_c;
            logic             src_v;
            logic [CW:0]      chunk;
            logic [WIDTH-1:0] sum_next;

            if (gi == 0) begin : g_head
                assign src_a   = a;
                assign src_b   = b;
                assign src_sum = '0;
                assign src_c   = cin;
                assign src_v   = in_valid;
            end else begin : g_body
                assign src_a   = a_q[gi-1];
                assign src_b   = b_q[gi-1];
                assign src_sum = sum_q[gi-1];
                assign src_c   = carry_q[gi-1];
                assign src_v   = valid_q[gi-1];
            end

            always_comb begin
                chunk = {1'b0, src_a[gi*CW +: CW]}
                      + {1'b0, src_b[gi*CW +: CW]}
                      + {{CW{1'b0}}, src_c};
                // Chunk gi of the incoming partial sum is always zero, because
                // no earlier stage writes it. So an OR inserts the new chunk.
                sum_next = src_sum | (WIDTH'(chunk[CW-1:0]) << (gi * CW));
            end

            assign valid_d[gi] = src_v;
            assign carry_d[gi] = chunk[CW];
            assign a_d[gi]     = src_a;
            assign b_d[gi]     = src_b;
            assign sum_d[gi]   = sum_next;

            if (gi == STAGES - 1) begin : g_tail
                logic msb_carry_in;
                // Carry into the MSB is recovered from the MSB sum bit.
                assign msb_carry_in = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ sum_next[WIDTH-1];
                assign ovf_d        = msb_carry_in ^ chunk[CW];
            end
        end
    endgenerate

    // The last stage's operand copies have no consumer.
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (adv) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign cout      = carry_q[STAGES-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_add.sv
// ---------------------------------------------------------------------------
// tb_pipe_add -- self-checking bench for pipe_add.
// Directed vectors and handshake corner cases run on an 8-bit, 2-stage
// instance. A random regression with random out_ready runs on 8- and 32-bit
// instances with 1, 2, 4 and 8 stages, checked against an a+b+cin model.
// ---------------------------------------------------------------------------
module tb_pipe_add;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int done_cnt  = 0;
    logic reg_start = 1'b0;

    pipe_add #(.WIDTH(8), .STAGES(2)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic mark_done();
        done_cnt++;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs [12];

    // One isolated transaction: accept, check that nothing appears after one
    // cycle, then check the result after two cycles.
    task automatic apply_one(input vec_t v, input string tag);
        @(negedge clk);
        in_valid = 1'b1; a = v.a; b = v.b; cin = v.cin;
        @(negedge clk);
        in_valid = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
        chk({tag, "_early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'd1);
        chk({tag, "_sum"},   64'(sum),       64'(v.sum));
        chk({tag, "_cout"},  64'(cout),      64'(v.cout));
        chk({tag, "_ovf"},   64'(ovf),       64'(v.ovf));
        $display("vec %s: %02h + %02h + %0d -> sum=%02h cout=%0b ovf=%0b",
                 tag, v.a, v.b, v.cin, sum, cout, ovf);
    endtask

    // ---------------- random regression, several configurations -----------
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_reg
            localparam int W = (gi < 4) ? 8 : 32;
            localparam int S = 1 << (gi % 4);

            logic         r_iv, r_ir, r_cin, r_ov, r_or, r_cout, r_ovf;
            logic [W-1:0] r_a, r_b, r_sum;
            logic [65:0]  exp_q [$];

            pipe_add #(.WIDTH(W), .STAGES(S)) u_dut (
                .clk(clk), .rst(rst),
                .in_valid(r_iv), .in_ready(r_ir),
                .a(r_a), .b(r_b), .cin(r_cin),
                .out_valid(r_ov), .out_ready(r_or),
                .sum(r_sum), .cout(r_cout), .ovf(r_ovf)
            );

            initial begin
                logic [W:0]  full;
                logic [65:0] e;
                r_iv = 1'b0; r_or = 1'b1; r_a = '0; r_b = '0; r_cin = 1'b0;
                wait (reg_start);
                for (int c = 0; c < 300; c++) begin
                    @(negedge clk);
                    r_iv  = (c < 270) && ($urandom_range(0, 3) != 0);
                    r_or  = (c >= 270) || ($urandom_range(0, 3) != 0);
                    r_a   = W'({$urandom(), $urandom()});
                    r_b   = W'({$urandom(), $urandom()});
                    r_cin = 1'($urandom_range(0, 1));
                    #2;
                    if (r_iv && r_ir) begin
                        full  = {1'b0, r_a} + {1'b0, r_b} + (W+1)'(r_cin);
                        e     = '0;
                        e[63:0] = 64'(full[W-1:0]);
                        e[64] = full[W];
                        e[65] = (r_a[W-1] == r_b[W-1]) && (full[W-1] != r_a[W-1]);
                        exp_q.push_back(e);
                    end
                    if (r_ov && r_or) begin
                        if (exp_q.size() == 0) begin
                            chk($sformatf("reg%0d_spurious", gi), 64'd1, 64'd0);
                        end else begin
                            e = exp_q.pop_front();
                            chk($sformatf("reg%0d_sum", gi),  64'(r_sum),  e[63:0]);
                            chk($sformatf("reg%0d_cout", gi), 64'(r_cout), 64'(e[64]));
                            chk($sformatf("reg%0d_ovf", gi),  64'(r_ovf),  64'(e[65]));
                        end
                    end
                end
                chk($sformatf("reg%0d_drained", gi), 64'(exp_q.size()), 64'd0);
                mark_done();
            end
        end
    endgenerate

    // ---------------- directed test on WIDTH=8, STAGES=2 --------------------
    initial begin
        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2]  = '{8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1};
        vecs[3]  = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        vecs[4]  = '{8'h0F, 8'h01, 1'b1, 8'h11, 1'b0, 1'b0};
        vecs[5]  = '{8'hF0, 8'h10, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[6]  = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        vecs[7]  = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8]  = '{8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[9]  = '{8'h08, 8'h08, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[10] = '{8'h40, 8'h40, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[11] = '{8'hC0, 8'h80, 1'b0, 8'h40, 1'b1, 1'b1};

        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; cin = 1'b0;
        #1 rst = 1'b1;

        // Reset state
        #11;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven isolated vectors
        for (int i = 0; i < 12; i++) apply_one(vecs[i], $sformatf("t%0d", i));

        // Streaming: three back-to-back inputs, three back-to-back outputs
        @(negedge clk);
        in_valid = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b1;
        @(negedge clk);
        chk("str0_valid", 64'(out_valid), 64'd1);
        chk("str0_sum",   64'(sum),       64'h30);
        chk("str0_cout",  64'(cout),      64'd0);
        $display("stream 0: sum=%02h cout=%0b", sum, cout);
        a = 8'hF0; b = 8'h10; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("str1_valid", 64'(out_valid), 64'd1);
        chk("str1_sum",   64'(sum),       64'h11);
        chk("str1_cout",  64'(cout),      64'd0);
        $display("stream 1: sum=%02h cout=%0b", sum, cout);
        @(negedge clk);
        chk("str2_valid", 64'(out_valid), 64'd1);
        chk("str2_sum",   64'(sum),       64'h00);
        chk("str2_cout",  64'(cout),      64'd1);
        $display("stream 2: sum=%02h cout=%0b", sum, cout);
        @(negedge clk);
        chk("str_empty", 64'(out_valid), 64'd0);

        // Backpressure: stall three cycles on the 0x30 result
        @(negedge clk);
        in_valid = 1'b1; a = 8'h10; b = 8'h20; cin = 1'b0;
        @(negedge clk);
        a = 8'h0F; b = 8'h01; cin = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_first_valid", 64'(out_valid), 64'd1);
        chk("bp_first_sum",   64'(sum),       64'h30);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("bp_hold%0d_sum", i),   64'(sum),       64'h30);
            chk($sformatf("bp_hold%0d_cout", i),  64'(cout),      64'd0);
            chk($sformatf("bp_hold%0d_ready", i), 64'(in_ready),  64'd0);
            // Operand changes while stalled must have no effect
            in_valid = (i < 2); a = 8'hA5 + 8'(i); b = 8'h5A; cin = 1'b1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_next_valid", 64'(out_valid), 64'd1);
        chk("bp_next_sum",   64'(sum),       64'h11);
        $display("backpressure release: sum=%02h", sum);
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // Reset mid-flight
        @(negedge clk);
        in_valid = 1'b1; a = 8'h55; b = 8'hAA; cin = 1'b0;
        @(negedge clk);
        a = 8'h33; b = 8'h33;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_sum",   64'(sum),       64'd0);
        chk("mid_rst_ready", 64'(in_ready),  64'd1);
        @(negedge clk);
        chk("mid_rst_valid2", 64'(out_valid), 64'd0);
        rst = 1'b0;
        a = 8'h01; b = 8'h01; cin = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        chk("post_rst_early", 64'(out_valid), 64'd0);
        chk("post_rst_sum0",  64'(sum),       64'd0);
        @(negedge clk);
        chk("post_rst_valid", 64'(out_valid), 64'd1);
        chk("post_rst_sum",   64'(sum),       64'h02);
        chk("post_rst_cout",  64'(cout),      64'd0);
        $display("post reset: sum=%02h", sum);
        @(negedge clk);
        chk("post_rst_empty", 64'(out_valid), 64'd0);

        // Random regression across configurations
        reg_start = 1'b1;
        for (int i = 0; i < 2000 && done_cnt < 8; i++) @(negedge clk);
        chk("regress_done", 64'(done_cnt), 64'd8);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
